sap_ram_16x8: RTL and testbench

- 16-word x 8-bit memory addressed by the 4-bit memory-address-register output of the SAP-style datapath.
- Reads the location the address register points to and drives it onto the shared bus one cycle later.
- Accepts bus writes in run mode.
- Provides a program mode with a nibble-serial loader, so the pad-limited top level can fill memory 4 bits at a time from dedicated inputs.

---
 rtl/sap_ram_16x8.sv | 81 ++++++++
 tb/tb_sap_ram_16x8.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sap_ram_16x8.sv
// 16x8 SAP-style RAM with a registered bus read port and a nibble-serial program loader.
// Run mode serves reads and writes from the MAR; program mode fills memory from 4-bit pads.
module sap_ram_16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ce,
    input  logic              we,
    input  logic [DATA_W-1:0] d_in,
    input  logic              prog,
    input  logic [NIB_W-1:0]  prog_nib,
    input  logic              prog_stb,
    output logic [DATA_W-1:0] data_out,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] prog_ptr,
    output logic              prog_hi,
    output logic              prog_done,
    output logic              wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        LD_HI,
        LD_LO
    } ld_state_t;

    ld_state_t         ld_state;
    logic [NIB_W-1:0]  hi_nib;
    logic [DATA_W-1:0] mem [DEPTH];

    // A read that collides with a write wins; the write is dropped and flagged until clr.
    always_ff @(posedge clk) begin
        prog_done <= 1'b0;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out    <= '0;
            bus_oe      <= 1'b0;
            prog_ptr    <= '0;
            hi_nib      <= '0;
            ld_state    <= LD_HI;
            wr_conflict <= 1'b0;
        end else if (prog) begin
            bus_oe <= 1'b0;
            if (prog_stb) begin
                if (ld_state == LD_HI) begin
                    hi_nib   <= prog_nib;
                    ld_state <= LD_LO;
                end else begin
                    mem[prog_ptr] <= {hi_nib, prog_nib};
                    prog_ptr      <= prog_ptr + ADDR_W'(1);
                    ld_state      <= LD_HI;
                    if (&prog_ptr) begin
                        prog_done <= 1'b1;
                    end
                end
            end
        end else begin
            // Leaving program mode mid-word drops the latched high nibble.
            ld_state <= LD_HI;
            bus_oe   <= ce;
            if (ce) begin
                data_out <= mem[addr];
                if (we) begin
                    wr_conflict <= 1'b1;
                end
            end else if (we) begin
                mem[addr] <= d_in;
            end
        end
    end

    assign prog_hi = (ld_state == LD_LO);

endmodule

// File: tb/tb_sap_ram_16x8.sv
// Directed bench for sap_ram_16x8: bus reads are checked by a scoreboard monitor,
// loader and status outputs are checked directly after each stimulus cycle.
module tb_sap_ram_16x8;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] addr = '0;
    logic       ce = 1'b0;
    logic       we = 1'b0;
    logic [7:0] d_in = '0;
    logic       prog = 1'b0;
    logic [3:0] prog_nib = '0;
    logic       prog_stb = 1'b0;
    logic [7:0] data_out;
    logic       bus_oe;
    logic [3:0] prog_ptr;
    logic       prog_hi;
    logic       prog_done;
    logic       wr_conflict;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    sap_ram_16x8 dut (
        .clk(clk),
        .clr(clr),
        .addr(addr),
        .ce(ce),
        .we(we),
        .d_in(d_in),
        .prog(prog),
        .prog_nib(prog_nib),
        .prog_stb(prog_stb),
        .data_out(data_out),
        .bus_oe(bus_oe),
        .prog_ptr(prog_ptr),
        .prog_hi(prog_hi),
        .prog_done(prog_done),
        .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs are applied at a falling edge and held across exactly one rising edge.
    task automatic apply_stimulus(input logic c, input logic p, input logic [3:0] a, input logic e,
                                  input logic w, input logic [7:0] d, input logic s, input logic [3:0] n);
        clr = c; prog = p; addr = a; ce = e; we = w; d_in = d; prog_stb = s; prog_nib = n;
        @(negedge clk);
    endtask

    task automatic idle(input logic p);
        apply_stimulus(1'b0, p, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        apply_stimulus(1'b0, 1'b0, a, 1'b0, 1'b1, d, 1'b0, 4'h0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] expected);
        exp_q.push_back(expected);
        apply_stimulus(1'b0, 1'b0, a, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    task automatic nibble(input logic [3:0] n);
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, n);
    endtask

    // Monitor: every cycle the DUT drives the bus, one queued expectation is consumed.
    initial begin
        logic [7:0] expected;
        forever begin
            @(posedge clk);
            #1;
            if (bus_oe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_bus_oe: got data_out 0x%0h, expected no read", data_out);
                end else begin
                    expected = exp_q.pop_front();
                    check_output("bus_read", 32'(data_out), 32'(expected));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        check_output("rst_data_out", 32'(data_out), 32'h00);
        check_output("rst_bus_oe", 32'(bus_oe), 32'h0);
        check_output("rst_prog_ptr", 32'(prog_ptr), 32'h0);
        check_output("rst_prog_hi", 32'(prog_hi), 32'h0);
        check_output("rst_prog_done", 32'(prog_done), 32'h0);
        check_output("rst_wr_conflict", 32'(wr_conflict), 32'h0);

        // Read latency and hold behaviour
        do_write(4'h3, 8'hA5);
        do_read(4'h3, 8'hA5);
        idle(1'b0);
        check_output("ce_low_bus_oe", 32'(bus_oe), 32'h0);
        check_output("ce_low_data_hold", 32'(data_out), 32'hA5);

        // Simultaneous we/ce: read wins, write dropped, sticky flag
        do_write(4'h7, 8'h11);
        exp_q.push_back(8'h11);
        apply_stimulus(1'b0, 1'b0, 4'h7, 1'b1, 1'b1, 8'h3C, 1'b0, 4'h0);
        check_output("conflict_flag", 32'(wr_conflict), 32'h1);
        idle(1'b0);
        do_read(4'h7, 8'h11);
        check_output("conflict_sticky", 32'(wr_conflict), 32'h1);

        // Entering program mode ignores ce and drops bus_oe
        apply_stimulus(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0);
        check_output("prog_bus_oe", 32'(bus_oe), 32'h0);
        check_output("prog_data_hold", 32'(data_out), 32'h11);
        check_output("prog_ptr_kept", 32'(prog_ptr), 32'h0);

        for (int i = 0; i < 16; i++) begin
            nibble(4'h1);
            if (i == 0) check_output("load_prog_hi", 32'(prog_hi), 32'h1);
            nibble(4'(i));
            check_output("load_prog_done", 32'(prog_done), (i == 15) ? 32'h1 : 32'h0);
            check_output("load_prog_ptr", 32'(prog_ptr), 32'((i + 1) % 16));
        end
        idle(1'b1);
        check_output("done_one_cycle", 32'(prog_done), 32'h0);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 8'(8'h10 + i));
        end

        // Abort mid-word, then resume at the same pointer
        nibble(4'h5);
        nibble(4'h5);
        nibble(4'hE);
        check_output("abort_prog_hi_set", 32'(prog_hi), 32'h1);
        idle(1'b0);
        check_output("abort_prog_hi_clr", 32'(prog_hi), 32'h0);
        check_output("abort_prog_ptr", 32'(prog_ptr), 32'h1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h9);
        check_output("run_stb_ignored_ptr", 32'(prog_ptr), 32'h1);
        check_output("run_stb_ignored_hi", 32'(prog_hi), 32'h0);
        nibble(4'h4);
        nibble(4'h2);
        check_output("resume_prog_ptr", 32'(prog_ptr), 32'h2);
        do_read(4'h1, 8'h42);
        do_read(4'h0, 8'h55);
        do_read(4'h2, 8'h12);

        // clr during a load wipes everything
        nibble(4'hA);
        nibble(4'hB);
        nibble(4'hC);
        check_output("midload_prog_hi", 32'(prog_hi), 32'h1);
        apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'hD);
        check_output("clr_prog_ptr", 32'(prog_ptr), 32'h0);
        check_output("clr_prog_hi", 32'(prog_hi), 32'h0);
        check_output("clr_wr_conflict", 32'(wr_conflict), 32'h0);
        check_output("clr_data_out", 32'(data_out), 32'h00);
        check_output("clr_bus_oe", 32'(bus_oe), 32'h0);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 8'h00);
        end
        idle(1'b0);
        idle(1'b0);

        check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
